// File: rtl/pll_reconfig_pkg.sv
// Register map, write record and the two PLL output profiles
// consumed by the reconfig sequencer.
package pll_reconfig_pkg;

    localparam logic [5:0] REG_MODE  = 6'h00;
    localparam logic [5:0] REG_START = 6'h02;
    localparam logic [5:0] REG_N     = 6'h03;
    localparam logic [5:0] REG_M     = 6'h04;
    localparam logic [5:0] REG_C     = 6'h05;
    localparam logic [5:0] REG_K     = 6'h07;

    localparam logic [31:0] MODE_POLL  = 32'h0000_0001;
    localparam logic [19:0] LOCK_BLANK = 20'd16;

    localparam int NUM_WR = 6;
    localparam logic [2:0] LAST_IDX = 3'(NUM_WR - 1);

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } pll_wr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MODE,
        S_WRTAB,
        S_START,
        S_WAITLOCK
    } state_e;

    // C-counter entries carry the counter select in data[22:18]
    localparam pll_wr_t PROFILE0 [NUM_WR] = '{
        {REG_K, 32'h0000_0006},
        {REG_M, 32'h0000_2423},
        {REG_N, 32'h0000_0505},
        {REG_C, 32'h0000_0404},
        {REG_C, 32'h0004_0808},
        {REG_C, 32'h0008_1818}
    };

    localparam pll_wr_t PROFILE1 [NUM_WR] = '{
        {REG_K, 32'h0000_0007},
        {REG_M, 32'h0002_1514},
        {REG_N, 32'h0000_0303},
        {REG_C, 32'h0000_0303},
        {REG_C, 32'h0004_0606},
        {REG_C, 32'h0008_1313}
    };

    function automatic pll_wr_t tab_entry(input logic prof,
                                          input logic [2:0] idx);
        return prof ? PROFILE1[idx] : PROFILE0[idx];
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchroniser for the asynchronous PLL locked flag.
module pll_lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// Avalon-MM write sequencer that switches the PLL between two
// profiles, holding the core in reset until relock, with retries.
module pll_reconfig_sequencer
    import pll_reconfig_pkg::*;
#(
    parameter logic [19:0] LOCK_TIMEOUT = 20'd1000000,
    parameter int          MAX_RETRY    = 2,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_req,
    input  logic        cfg_profile,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        core_reset,
    output logic        cur_profile
);

    localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);
    localparam logic [19:0] TMO_LAST  = LOCK_TIMEOUT - 20'd1;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        gap_q, gap_d;
    logic        wr_q, wr_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        prof_q, prof_d;
    logic [7:0]  retry_q, retry_d;
    logic [19:0] tmo_q, tmo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        crst_q, crst_d;
    logic        cur_q, cur_d;

    logic    locked_sync;
    pll_wr_t cur_wr;

    pll_lock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (pll_locked),
        .q_o    (locked_sync)
    );

    always_comb begin
        cur_wr = {REG_START, 32'h0};
        if (state_q == S_MODE) begin
            cur_wr = {REG_MODE, MODE_POLL};
        end else if (state_q == S_WRTAB) begin
            cur_wr = tab_entry(prof_q, idx_q);
        end
    end

    // Every write is a gap cycle followed by the strobe, held through stalls
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        prof_d  = prof_q;
        retry_d = retry_q;
        tmo_d   = tmo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        crst_d  = crst_q;
        cur_d   = cur_q;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_req) begin
                    prof_d  = cfg_profile;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    crst_d  = 1'b1;
                    retry_d = '0;
                    gap_d   = 1'b1;
                    state_d = S_MODE;
                end else if (locked_sync) begin
                    crst_d = 1'b0;
                end
            end
            S_MODE, S_WRTAB, S_START: begin
                if (gap_q) begin
                    gap_d  = 1'b0;
                    wr_d   = 1'b1;
                    addr_d = cur_wr.addr;
                    data_d = cur_wr.data;
                end else if (wr_q && !mgmt_waitrequest) begin
                    wr_d  = 1'b0;
                    gap_d = 1'b1;
                    if (state_q == S_MODE) begin
                        idx_d   = '0;
                        state_d = S_WRTAB;
                    end else if (state_q == S_WRTAB) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_START;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        gap_d   = 1'b0;
                        tmo_d   = '0;
                        state_d = S_WAITLOCK;
                    end
                end
            end
            S_WAITLOCK: begin
                if (tmo_q >= LOCK_BLANK && locked_sync) begin
                    done_d  = 1'b1;
                    cur_d   = prof_q;
                    busy_d  = 1'b0;
                    crst_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 8'd1;
                        gap_d   = 1'b1;
                        state_d = S_MODE;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 20'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            prof_q  <= 1'b0;
            retry_q <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            crst_q  <= 1'b1;
            cur_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            prof_q  <= prof_d;
            retry_q <= retry_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            crst_q  <= crst_d;
            cur_q   <= cur_d;
        end
    end

    assign mgmt_address   = addr_q;
    assign mgmt_write     = wr_q;
    assign mgmt_writedata = data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = err_q;
    assign core_reset     = crst_q;
    assign cur_profile    = cur_q;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Directed bench for pll_reconfig_sequencer with a write monitor.
module tb_pll_reconfig_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_req;
    logic        cfg_profile;
    logic        pll_locked;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic        core_reset;
    logic        cur_profile;

    always #10 clk = ~clk;

    pll_reconfig_sequencer #(
        .LOCK_TIMEOUT (20'd100),
        .MAX_RETRY    (2),
        .SYNC_STAGES  (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cfg_req          (cfg_req),
        .cfg_profile      (cfg_profile),
        .pll_locked       (pll_locked),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .core_reset       (core_reset),
        .cur_profile      (cur_profile)
    );

    logic [5:0]  exp_addr [8] = '{6'h00, 6'h07, 6'h04, 6'h03,
                                  6'h05, 6'h05, 6'h05, 6'h02};
    logic [31:0] exp_d0 [8] = '{32'h1, 32'h6, 32'h2423, 32'h505,
                                32'h404, 32'h40808, 32'h81818, 32'h0};
    logic [31:0] exp_d1 [8] = '{32'h1, 32'h7, 32'h21514, 32'h303,
                                32'h303, 32'h40606, 32'h81313, 32'h0};

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor, sampled on the falling edge
    logic [5:0]  wa [$];
    logic [31:0] wd [$];
    int          cyc = 0;
    int          nstall = 0;
    int          ndone = 0;
    int          req_cyc = 0;
    int          start_cyc = 0;
    int          viol = 0;
    logic        prev_stall = 1'b0;
    logic        prev_cmpl = 1'b0;
    logic [5:0]  prev_a = '0;
    logic [31:0] prev_d = '0;

    always @(negedge clk) begin
        cyc++;
        if (prev_stall && (!mgmt_write || mgmt_address !== prev_a ||
                           mgmt_writedata !== prev_d))
            viol++;
        if (prev_cmpl && mgmt_write)
            viol++;
        prev_stall = mgmt_write && mgmt_waitrequest;
        prev_cmpl  = mgmt_write && !mgmt_waitrequest;
        prev_a     = mgmt_address;
        prev_d     = mgmt_writedata;
        if (mgmt_write && mgmt_waitrequest)
            nstall++;
        if (mgmt_write && !mgmt_waitrequest) begin
            wa.push_back(mgmt_address);
            wd.push_back(mgmt_writedata);
            if (mgmt_address == 6'h02)
                start_cyc = cyc;
        end
        if (done)
            ndone++;
        if (cfg_req)
            req_cyc = cyc;
    end

    // Optional stall generator: 3 waitrequest cycles per write
    logic stall_en = 1'b0;
    int   stall_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (stall_en && mgmt_write && stall_cnt < 3) begin
            mgmt_waitrequest = 1'b1;
            stall_cnt++;
        end else begin
            mgmt_waitrequest = 1'b0;
            stall_cnt = 0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        nstall = 0;
        ndone = 0;
    endtask

    task automatic start_cfg(input logic prof);
        cfg_profile = prof;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        pll_locked = 1'b0;
    endtask

    task automatic wait_wr(input string tag, input int n, input int budget);
        int k = 0;
        while (wa.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_wr_seen"}, 64'(wa.size() >= n), 64'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (ndone == 0 && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_done_seen"}, 64'(ndone != 0), 64'd1);
    endtask

    task automatic chk_seq(input string tag, input logic prof,
                           input int base);
        logic [63:0] got;
        for (int i = 0; i < 8; i++) begin
            got = '1;
            if (base + i < wa.size())
                got = 64'({wa[base+i], wd[base+i]});
            chk($sformatf("%s_wr%0d", tag, i), got,
                64'({exp_addr[i], prof ? exp_d1[i] : exp_d0[i]}));
        end
    endtask

    initial begin
        int k;
        reset_n = 1'b0;
        cfg_req = 1'b0;
        cfg_profile = 1'b0;
        pll_locked = 1'b0;

        // 1: reset values, then release of core_reset on lock
        tick(3);
        chk("rst_write", 64'(mgmt_write), 64'd0);
        chk("rst_addr", 64'(mgmt_address), 64'd0);
        chk("rst_data", 64'(mgmt_writedata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_cur", 64'(cur_profile), 64'd0);
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        reset_n = 1'b1;
        tick(10);
        pll_locked = 1'b1;
        tick(2);
        chk("t1_core_reset_held", 64'(core_reset), 64'd1);
        tick(1);
        chk("t1_core_reset_rel", 64'(core_reset), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);

        // 2: profile 1, no stalls, lock returns 40 cycles after START
        clear_log();
        start_cfg(1'b1);
        chk("t2_busy", 64'(busy), 64'd1);
        chk("t2_core_reset", 64'(core_reset), 64'd1);
        wait_wr("t2", 8, 200);
        chk("t2_latency", 64'(start_cyc - req_cyc), 64'd16);
        tick(39);
        pll_locked = 1'b1;
        wait_done("t2", 60);
        tick(5);
        chk("t2_done_cnt", 64'(ndone), 64'd1);
        chk("t2_nwr", 64'(wa.size()), 64'd8);
        chk_seq("t2", 1'b1, 0);
        chk("t2_cur", 64'(cur_profile), 64'd1);
        chk("t2_busy_end", 64'(busy), 64'd0);
        chk("t2_core_reset_end", 64'(core_reset), 64'd0);

        // 3: profile 0 with 3 stall cycles on every write
        clear_log();
        stall_en = 1'b1;
        start_cfg(1'b0);
        wait_wr("t3", 8, 300);
        stall_en = 1'b0;
        tick(20);
        pll_locked = 1'b1;
        wait_done("t3", 60);
        tick(3);
        chk("t3_nwr", 64'(wa.size()), 64'd8);
        chk("t3_nstall", 64'(nstall), 64'd24);
        chk_seq("t3", 1'b0, 0);
        chk("t3_done_cnt", 64'(ndone), 64'd1);
        chk("t3_cur", 64'(cur_profile), 64'd0);

        // 4: lock never returns -> two retries then error
        clear_log();
        start_cfg(1'b1);
        k = 0;
        while (!error && k < 1500) begin
            tick();
            k++;
        end
        chk("t4_error", 64'(error), 64'd1);
        chk("t4_nwr", 64'(wa.size()), 64'd24);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_core_reset", 64'(core_reset), 64'd1);
        chk("t4_done", 64'(ndone), 64'd0);
        chk("t4_cur", 64'(cur_profile), 64'd0);
        chk_seq("t4_seq3", 1'b1, 16);
        pll_locked = 1'b1;
        tick(4);
        chk("t4_recover_rst", 64'(core_reset), 64'd0);
        chk("t4_err_sticky", 64'(error), 64'd1);
        clear_log();
        start_cfg(1'b0);
        chk("t4_err_clr", 64'(error), 64'd0);
        chk("t4_busy2", 64'(busy), 64'd1);
        chk("t4_core_reset2", 64'(core_reset), 64'd1);
        wait_wr("t4b", 8, 200);
        tick(20);
        pll_locked = 1'b1;
        wait_done("t4b", 60);
        tick(3);
        chk("t4_done_cnt", 64'(ndone), 64'd1);

        // 5: stray request during table writes is dropped
        clear_log();
        start_cfg(1'b1);
        k = 0;
        while (wa.size() < 3 && k < 100) begin
            tick();
            k++;
        end
        cfg_profile = 1'b0;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        chk("t5_busy", 64'(busy), 64'd1);
        wait_wr("t5", 8, 200);
        tick(20);
        pll_locked = 1'b1;
        wait_done("t5", 60);
        tick(30);
        chk("t5_done_cnt", 64'(ndone), 64'd1);
        chk("t5_nwr", 64'(wa.size()), 64'd8);
        chk_seq("t5", 1'b1, 0);
        chk("t5_cur", 64'(cur_profile), 64'd1);

        // 6: async reset while waiting for lock
        clear_log();
        start_cfg(1'b0);
        wait_wr("t6", 8, 200);
        tick(5);
        #5;
        reset_n = 1'b0;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_core_reset", 64'(core_reset), 64'd1);
        chk("t6_write", 64'(mgmt_write), 64'd0);
        chk("t6_addr", 64'(mgmt_address), 64'd0);
        chk("t6_error", 64'(error), 64'd0);
        chk("t6_cur", 64'(cur_profile), 64'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        pll_locked = 1'b1;
        tick(4);
        chk("t6_core_reset_rel", 64'(core_reset), 64'd0);
        clear_log();
        start_cfg(1'b1);
        wait_wr("t6b", 8, 200);
        tick(20);
        pll_locked = 1'b1;
        wait_done("t6b", 60);
        tick(3);
        chk_seq("t6b", 1'b1, 0);
        chk("t6_done_cnt", 64'(ndone), 64'd1);
        chk("t6_cur_after", 64'(cur_profile), 64'd1);

        chk("bus_protocol", 64'(viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
